// File: rtl/md6_hash_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md6_hash_uart_tx_pkg
// Description : Shared constants, FSM state encoding and the digest byte-count
//               helper for the MD6 digest UART transmitter.
//               Optional feature macro: MD6_TX_PARITY_EN (adds a PARITY state).
// Revision    : 1.0 - initial release
// ============================================================================
package md6_hash_uart_tx_pkg;

  // Largest MD6 digest length in bits, and the default line rate
  localparam int MD6_MAX_D     = 512;
  localparam int MD6_BAUD_RATE = 9600;

  // Transmitter states, explicit 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_STOP   = 3'd4,
`ifdef MD6_TX_PARITY_EN
    ST_PARITY = 3'd6,
`endif
    ST_DONE   = 3'd5
  } tx_state_e;

  // Number of bytes needed to carry a d-bit digest, clamped to the bus width
  function automatic logic [7:0] byte_count(input logic [15:0] d, input int max_bytes);
    logic [16:0] rounded;
    rounded = {1'b0, d} + 17'd7;
    if (int'(d) > 8 * max_bytes) begin
      return 8'(max_bytes);
    end
    return rounded[10:3];
  endfunction

endpackage
`default_nettype wire

// File: rtl/md6_hash_uart_tx_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : md6_baud_tick
// Description : Bit-period timer. Pulses tick on the last clock of every
//               BAUD_DIV-clock bit period while run is high; the count is held
//               at zero while run is low so the first bit is a full period.
// Revision    : 1.0 - initial release
// ============================================================================
module md6_baud_tick #(
  parameter int BAUD_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int              CNT_W    = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Terminal count of the current bit period
  always_comb begin
    tick  = run && (cnt_q == CNT_LAST);
    cnt_d = cnt_q + CNT_W'(1);
    if (!run || tick) begin
      cnt_d = '0;
    end
  end

  // Period counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/md6_hash_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : md6_hash_uart_tx
// Description : Captures a d-bit MD6 digest on a rising transmit request and
//               sends ceil(d/8) bytes, most-significant byte first, as UART
//               frames on TxD (8N1, or 8E1 when MD6_TX_PARITY_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
module md6_hash_uart_tx
  import md6_hash_uart_tx_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = MD6_BAUD_RATE,
  parameter int HASH_W    = MD6_MAX_D
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              transmit,
  input  logic [15:0]       d,
  input  logic [HASH_W-1:0] data,
  output logic              TxD,
  output logic              busy,
  output logic              done
);

  localparam int BAUD_DIV   = CLK_FREQ / BAUD_RATE;
  localparam int HASH_BYTES = HASH_W / 8;
  localparam int SHIFT_W    = $clog2(HASH_W + 1);

  tx_state_e         state_q, state_d;
  logic [HASH_W-1:0] shreg_q, shreg_d;
  logic [7:0]        byte_cnt_q, byte_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic              txd_q, txd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              transmit_q, transmit_d;

  logic              req_edge;
  logic [7:0]        nb;
  logic [SHIFT_W-1:0] shift_amt;
  logic [7:0]        top_byte;
  logic [2:0]        next_idx;
  logic              run;
  logic              bit_tick;

  // Request decode, byte count and the left-alignment shift for the digest
  always_comb begin
    transmit_d = transmit;
    req_edge   = transmit & ~transmit_q;
    nb         = byte_count(d, HASH_BYTES);
    shift_amt  = SHIFT_W'(HASH_W - 8 * int'(nb));
    top_byte   = shreg_q[HASH_W-1 -: 8];
    next_idx   = bit_idx_q + 3'd1;
    // The line is being timed in every busy state except the single LOAD cycle
    run        = busy_q && (state_q != ST_LOAD);
  end

  md6_baud_tick #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_tick (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .tick  (bit_tick)
  );

  // Next-state logic: each output bit is decided on the transition into its period
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    byte_cnt_d = byte_cnt_q;
    bit_idx_d  = bit_idx_q;
    txd_d      = txd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (req_edge) begin
          if (nb == 8'd0) begin
            // Zero-length digest: acknowledge without touching the line
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = ST_LOAD;
            shreg_d    = data << shift_amt;
            byte_cnt_d = nb;
            busy_d     = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        state_d   = ST_START;
        txd_d     = 1'b0;
        bit_idx_d = 3'd0;
      end
      ST_START: begin
        if (bit_tick) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
          txd_d     = top_byte[0];
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          if (bit_idx_q == 3'd7) begin
`ifdef MD6_TX_PARITY_EN
            state_d = ST_PARITY;
            txd_d   = ^top_byte;
`else
            state_d = ST_STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            bit_idx_d = next_idx;
            txd_d     = top_byte[next_idx];
          end
        end
      end
`ifdef MD6_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_tick) begin
          state_d = ST_STOP;
          txd_d   = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (bit_tick) begin
          shreg_d    = shreg_q << 8;
          byte_cnt_d = byte_cnt_q - 8'd1;
          if (byte_cnt_q > 8'd1) begin
            // Next start bit follows the stop bit with no idle gap
            state_d = ST_START;
            txd_d   = 1'b0;
          end else begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      byte_cnt_q <= 8'd0;
      bit_idx_q  <= 3'd0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      transmit_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      byte_cnt_q <= byte_cnt_d;
      bit_idx_q  <= bit_idx_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      transmit_q <= transmit_d;
    end
  end

  assign TxD  = txd_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_md6_hash_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_md6_hash_uart_tx
// Description : Self-checking bench for md6_hash_uart_tx. A mid-bit sampling
//               UART receiver decodes TxD; bytes, timing, busy and done are
//               compared against values computed from the digest.
//               Honours MD6_TX_PARITY_EN (8E1 frames).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md6_hash_uart_tx;

  localparam int DIV = 4;
`ifdef MD6_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         transmit;
  logic [15:0]  d_in;
  logic [511:0] data_in;
  logic         TxD;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;
  logic [7:0] rx_q[$];

  typedef struct {
    logic [15:0]  d;
    logic [511:0] data;
    int           exp_nb;
  } vec_t;
  vec_t vecs[$];

  md6_hash_uart_tx #(
    .CLK_FREQ  (40),
    .BAUD_RATE (10),
    .HASH_W    (512)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .transmit (transmit),
    .d        (d_in),
    .data     (data_in),
    .TxD      (TxD),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: bytes needed for a d-bit digest
  function automatic int model_nb(input logic [15:0] dv);
    if (dv == 16'd0) return 0;
    if (dv > 16'd512) return 64;
    return (int'(dv) + 7) / 8;
  endfunction

  // Reference: j-th byte on the line is the j-th byte of the digest counted from its top
  function automatic logic [7:0] model_byte(input logic [511:0] dat, input int nb, input int j);
    return dat[8 * (nb - 1 - j) +: 8];
  endfunction

  // UART receiver: sample each bit in its middle, abandon the frame on reset
  initial begin : uart_rx
    logic [10:0] bits;
    bit          abort;
    bits = '0;
    forever begin
      @(negedge clk);
      if (!reset && TxD == 1'b0) begin
        abort = 1'b0;
        for (int s = 0; s < FRAME_BITS; s++) begin
          for (int w = 0; w < ((s == 0) ? DIV / 2 : DIV); w++) begin
            @(negedge clk);
            if (reset) abort = 1'b1;
          end
          if (abort) break;
          bits[s] = TxD;
        end
        if (!abort) begin
          chk("rx start bit", 64'(bits[0]), 64'd0);
          chk("rx stop bit", 64'(bits[FRAME_BITS-1]), 64'd1);
`ifdef MD6_TX_PARITY_EN
          chk("rx even parity", 64'(bits[9]), 64'(^bits[8:1]));
`endif
          rx_q.push_back(bits[8:1]);
        end
      end
    end
  end

  // One request: measure start latency, line time, busy span, done pulses and bytes
  task automatic send_and_check(input logic [15:0] dv, input logic [511:0] dat,
                                input int exp_nb, input bit disturb, input string tag);
    int k, first_low, done_k, busy_cnt, done_cnt, line_clks, limit;
    line_clks = exp_nb * FRAME_BITS * DIV;
    limit     = 2 + 64 * 11 * DIV + 20;
    first_low = -1; done_k = -1; busy_cnt = 0; done_cnt = 0; k = 0;
    @(negedge clk);
    rx_q.delete();
    d_in = dv; data_in = dat; transmit = 1'b1;
    while (k < limit) begin
      @(posedge clk); #1;
      k++;
      if (TxD == 1'b0 && first_low < 0) first_low = k;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (disturb && k == 20) transmit = 1'b0;
      if (disturb && k == 24) begin
        transmit = 1'b1;
        data_in  = ~dat;
        d_in     = 16'd64;
      end
      if (done_k > 0 && k >= done_k + 3) break;
    end
    transmit = 1'b0;
    chk($sformatf("%s first low clk", tag), 64'(first_low), 64'((exp_nb > 0) ? 2 : -1));
    chk($sformatf("%s done clk", tag), 64'(done_k), 64'((exp_nb > 0) ? 2 + line_clks : 1));
    chk($sformatf("%s busy clks", tag), 64'(busy_cnt), 64'((exp_nb > 0) ? 1 + line_clks : 0));
    chk($sformatf("%s done pulses", tag), 64'(done_cnt), 64'd1);
    chk($sformatf("%s byte count", tag), 64'(rx_q.size()), 64'(exp_nb));
    for (int j = 0; j < exp_nb && j < rx_q.size(); j++) begin
      chk($sformatf("%s byte %0d", tag, j), 64'(rx_q[j]), 64'(model_byte(dat, model_nb(dv), j)));
    end
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [511:0] inc_pat;
    logic [511:0] rnd;
    logic [15:0]  dr;
    int           k;

    reset = 1'b1; transmit = 1'b0; d_in = '0; data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset TxD", 64'(TxD), 64'd1);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);

    inc_pat = '0;
    inc_pat[255:0] = {4{64'h0123456789ABCDEF}};
    vecs.push_back('{16'd8,   512'h A5,  1});
    vecs.push_back('{16'd256, inc_pat,   32});
    vecs.push_back('{16'd12,  512'h ABC, 2});
    vecs.push_back('{16'd0,   512'h0,    0});
    vecs.push_back('{16'd600, {16{32'hC3A5_5A3C}}, 64});
    vecs.push_back('{16'd512, {16{32'h1357_9BDF}}, 64});
    vecs.push_back('{16'd1,   512'h1,    1});
`ifdef MD6_TX_PARITY_EN
    vecs.push_back('{16'd8,   512'h07,   1});
    vecs.push_back('{16'd8,   512'h03,   1});
`endif
    foreach (vecs[i]) begin
      send_and_check(vecs[i].d, vecs[i].data, vecs[i].exp_nb, 1'b0, $sformatf("vec%0d", i));
      repeat (3) @(negedge clk);
    end

    // Second request edge and digest change while a frame is in flight
    send_and_check(16'd16, 512'h1234, 2, 1'b1, "disturb");
    repeat (3) @(negedge clk);

    // Reset during bit 3 of the second byte, then a fresh full request
    @(negedge clk);
    d_in = 16'd16; data_in = 512'h5AA5; transmit = 1'b1;
    for (k = 0; k < 59; k++) begin
      @(posedge clk);
    end
    #1;
    chk("pre-reset TxD bit3", 64'(TxD), 64'd0);
    chk("pre-reset busy", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid-frame reset TxD", 64'(TxD), 64'd1);
    chk("mid-frame reset busy", 64'(busy), 64'd0);
    transmit = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    send_and_check(16'd16, 512'h5AA5, 2, 1'b0, "after reset");
    repeat (3) @(negedge clk);

    // Random digests of random length
    for (int r = 0; r < 6; r++) begin
      dr = 16'($urandom_range(1, 512));
      for (int w = 0; w < 16; w++) rnd[32*w +: 32] = $urandom;
      for (int b = 0; b < 512; b++) if (b >= int'(dr)) rnd[b] = 1'b0;
      send_and_check(dr, rnd, model_nb(dr), 1'b0, $sformatf("rand%0d d=%0d", r, dr));
      repeat (2) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
